// File: rtl/operm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operm_pkg
// Brief    : Shared definitions for the operand-permute stage: opcodes,
//            valid-opcode test and kp sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package operm_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_P8  = 4'd8;
  localparam logic [OP_W-1:0] OP_P9  = 4'd9;
  localparam logic [OP_W-1:0] OP_P13 = 4'd13;
  localparam logic [OP_W-1:0] OP_P14 = 4'd14;
  localparam logic [OP_W-1:0] OP_P15 = 4'd15;

  typedef enum logic [0:0] {
    KPS_IDLE  = 1'b0,
    KPS_ISSUE = 1'b1
  } kpseq_state_t;

  // Single definition of the opcodes the permute join acts on.
  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return (op == OP_P8)  || (op == OP_P9)  || (op == OP_P13) ||
           (op == OP_P14) || (op == OP_P15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operm_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : operm_prog_mem
// Brief    : DEPTH x (4+CNTW) program register file, synchronous write,
//            two asynchronous read ports (current and lookahead), no reset.
// Revision : 1.0 - initial release
// ============================================================================
module operm_prog_mem #(
  parameter int DEPTH = 16,
  parameter int CNTW  = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int DW   = 4 + CNTW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_cur_addr,
  output logic [DW-1:0] o_cur_data,
  input  logic [AW-1:0] i_nxt_addr,
  output logic [DW-1:0] o_nxt_data
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see the pre-write contents when a write lands in the same cycle.
  assign o_cur_data = r_mem[i_cur_addr];
  assign o_nxt_data = r_mem[i_nxt_addr];

endmodule
`default_nettype wire

// File: rtl/operm_kp_seq.sv
`default_nettype none
// ============================================================================
// Module   : operm_kp_seq
// Brief    : Replays a stored (opcode, repeat) program as k_ctrl tokens on the
//            kp req/ack handshake with repeat and whole-program loop counts.
// Revision : 1.0 - initial release
// ============================================================================
module operm_kp_seq
  import operm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNTW  = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [3:0]      cfg_op,
  input  logic [CNTW-1:0] cfg_rpt,
  input  logic [AW:0]     cfg_len,
  input  logic [CNTW-1:0] cfg_loops,
  input  logic            start,
  input  logic            abort,
  output logic            kp_req,
  input  logic            kp_ack,
  output logic [3:0]      k_ctrl,
  output logic            busy,
  output logic            done,
  output logic            inv_seen
);

  localparam int DW = 4 + CNTW;

  localparam logic [AW:0]     c_len_one = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]   c_pc_one  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

  kpseq_state_t r_state;
  kpseq_state_t w_state_nxt;

  logic            r_kp_req;
  logic [3:0]      r_k_ctrl;
  logic [AW-1:0]   r_pc;
  logic [CNTW-1:0] r_rpt_cnt;
  logic [CNTW-1:0] r_loop_cnt;
  logic [AW:0]     r_len;
  logic            r_done;
  logic            r_inv_seen;

  logic            w_kp_req_nxt;
  logic [3:0]      w_k_ctrl_nxt;
  logic [AW-1:0]   w_pc_nxt;
  logic [CNTW-1:0] w_rpt_cnt_nxt;
  logic [CNTW-1:0] w_loop_cnt_nxt;
  logic [AW:0]     w_len_nxt;
  logic            w_done_nxt;
  logic            w_inv_seen_nxt;

  logic            w_mem_we;
  logic [DW-1:0]   w_e0_data;
  logic [DW-1:0]   w_la_data;
  logic [AW-1:0]   w_la_addr;
  logic            w_xfer;
  logic            w_last_entry;

  // Entry 0 is the (re)start point; lookahead reads pc+1 so the next token
  // can be loaded at the same edge as the current transfer.
  assign w_la_addr = r_pc + c_pc_one;

  operm_prog_mem #(
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_prog_mem (
    .clk        (clk),
    .i_we       (w_mem_we),
    .i_waddr    (cfg_addr),
    .i_wdata    ({cfg_op, cfg_rpt}),
    .i_cur_addr ({AW{1'b0}}),
    .o_cur_data (w_e0_data),
    .i_nxt_addr (w_la_addr),
    .o_nxt_data (w_la_data)
  );

  assign w_xfer       = r_kp_req & kp_ack;
  assign w_last_entry = ({1'b0, r_pc} == (r_len - c_len_one));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= KPS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_kp_req_nxt   = r_kp_req;
    w_k_ctrl_nxt   = r_k_ctrl;
    w_pc_nxt       = r_pc;
    w_rpt_cnt_nxt  = r_rpt_cnt;
    w_loop_cnt_nxt = r_loop_cnt;
    w_len_nxt      = r_len;
    w_done_nxt     = 1'b0;
    w_inv_seen_nxt = r_inv_seen;
    w_mem_we       = 1'b0;

    case (r_state)
      KPS_IDLE: begin
        w_mem_we = cfg_we;
        if (start) begin
          w_inv_seen_nxt = 1'b0;
          w_len_nxt      = cfg_len;
          w_loop_cnt_nxt = cfg_loops;
          w_pc_nxt       = {AW{1'b0}};
          if (cfg_len == {(AW+1){1'b0}}) begin
            w_done_nxt = 1'b1;
          end else begin
            w_rpt_cnt_nxt = w_e0_data[CNTW-1:0];
            w_k_ctrl_nxt  = w_e0_data[DW-1:CNTW];
            w_kp_req_nxt  = 1'b1;
            w_state_nxt   = KPS_ISSUE;
          end
        end
      end

      KPS_ISSUE: begin
        if (w_xfer) begin
          if (!is_valid_op(r_k_ctrl)) begin
            w_inv_seen_nxt = 1'b1;
          end
          if (r_rpt_cnt != {CNTW{1'b0}}) begin
            w_rpt_cnt_nxt = r_rpt_cnt - c_cnt_one;
          end else if (!w_last_entry) begin
            w_pc_nxt      = w_la_addr;
            w_rpt_cnt_nxt = w_la_data[CNTW-1:0];
            w_k_ctrl_nxt  = w_la_data[DW-1:CNTW];
          end else if (r_loop_cnt != {CNTW{1'b0}}) begin
            w_loop_cnt_nxt = r_loop_cnt - c_cnt_one;
            w_pc_nxt       = {AW{1'b0}};
            w_rpt_cnt_nxt  = w_e0_data[CNTW-1:0];
            w_k_ctrl_nxt   = w_e0_data[DW-1:CNTW];
          end else begin
            w_kp_req_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = KPS_IDLE;
          end
        end
        // Abort wins over any completion in the same cycle, but a transfer
        // that coincides with it has still happened.
        if (abort) begin
          w_kp_req_nxt = 1'b0;
          w_done_nxt   = 1'b0;
          w_state_nxt  = KPS_IDLE;
        end
      end

      default: begin
        w_kp_req_nxt = 1'b0;
        w_state_nxt  = KPS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kp_req   <= 1'b0;
      r_k_ctrl   <= 4'd0;
      r_pc       <= {AW{1'b0}};
      r_rpt_cnt  <= {CNTW{1'b0}};
      r_loop_cnt <= {CNTW{1'b0}};
      r_len      <= {(AW+1){1'b0}};
      r_done     <= 1'b0;
      r_inv_seen <= 1'b0;
    end else begin
      r_kp_req   <= w_kp_req_nxt;
      r_k_ctrl   <= w_k_ctrl_nxt;
      r_pc       <= w_pc_nxt;
      r_rpt_cnt  <= w_rpt_cnt_nxt;
      r_loop_cnt <= w_loop_cnt_nxt;
      r_len      <= w_len_nxt;
      r_done     <= w_done_nxt;
      r_inv_seen <= w_inv_seen_nxt;
    end
  end

  assign kp_req   = r_kp_req;
  assign k_ctrl   = r_k_ctrl;
  assign busy     = (r_state == KPS_ISSUE);
  assign done     = r_done;
  assign inv_seen = r_inv_seen;

endmodule
`default_nettype wire

// File: tb/tb_operm_kp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_operm_kp_seq
// Brief    : Directed and randomized bench for operm_kp_seq against a token
//            list model built from the stored program.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operm_kp_seq;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_op;
  logic [7:0] cfg_rpt;
  logic [4:0] cfg_len;
  logic [7:0] cfg_loops;
  logic       start;
  logic       abort;
  logic       kp_req;
  logic       kp_ack;
  logic [3:0] k_ctrl;
  logic       busy;
  logic       done;
  logic       inv_seen;

  int n_tests = 0;
  int n_fail  = 0;

  int         prog_op  [16];
  int         prog_rpt [16];
  logic [3:0] expq[$];
  bit         exp_inv;

  operm_kp_seq #(.DEPTH(16), .CNTW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_op    (cfg_op),
    .cfg_rpt   (cfg_rpt),
    .cfg_len   (cfg_len),
    .cfg_loops (cfg_loops),
    .start     (start),
    .abort     (abort),
    .kp_req    (kp_req),
    .kp_ack    (kp_ack),
    .k_ctrl    (k_ctrl),
    .busy      (busy),
    .done      (done),
    .inv_seen  (inv_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_valid(input int op);
    return (op == 8) || (op == 9) || (op >= 13);
  endfunction

  // Token list = loops+1 passes over entries 0..len-1, each entry rpt+1 times.
  function automatic void build_expected(input int len, input int loops);
    expq.delete();
    for (int l = 0; l <= loops; l++)
      for (int i = 0; i < len; i++)
        for (int r = 0; r <= prog_rpt[i]; r++)
          expq.push_back(4'(prog_op[i]));
  endfunction

  task automatic write_entry(input int addr, input int op, input int rpt);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_op = 4'(op); cfg_rpt = 8'(rpt);
    @(negedge clk);
    cfg_we = 1'b0;
    prog_op[addr] = op; prog_rpt[addr] = rpt;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_req", kp_req, 0);
    check("idle_busy", busy, 0);
  endtask

  // ack_mode: 0 always, 1 pattern 1,0,0, 2 random.
  task automatic run_prog(input int len, input int loops, input int ack_mode,
                          input bit junk_we, input bit sim_we);
    int  cyc;
    int  xfers;
    int  total;
    bit  fin;
    bit  ack;
    build_expected(len, loops);
    total   = expq.size();
    exp_inv = 1'b0;
    check("pre_req", kp_req, 0);
    check("pre_busy", busy, 0);
    cfg_len = 5'(len); cfg_loops = 8'(loops); start = 1'b1;
    if (sim_we) begin
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_op = 4'd14; cfg_rpt = 8'd1; abort = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0; abort = 1'b0;
    if (sim_we) begin
      prog_op[0] = 14; prog_rpt[0] = 1;
    end
    check("start_inv_clr", inv_seen, 0);
    cyc = 0; xfers = 0; fin = 1'b0;
    while (1) begin
      if (fin) begin
        cfg_we = 1'b0; kp_ack = 1'b0;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_req", kp_req, 0);
        check("end_inv", inv_seen, 32'(exp_inv));
        break;
      end
      if (cyc >= 3000) begin
        kp_ack = 1'b0; cfg_we = 1'b0;
        check("timeout_xfers", xfers, total);
        break;
      end
      check("run_req", kp_req, 1);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("token", k_ctrl, expq[0]);
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 3 == 0);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      if (junk_we) begin
        cfg_we = 1'b1; cfg_addr = 4'($urandom); cfg_op = 4'($urandom); cfg_rpt = 8'($urandom);
      end
      kp_ack = ack;
      if (ack) begin
        if (!model_valid(int'(expq[0]))) exp_inv = 1'b1;
        void'(expq.pop_front());
        xfers++;
        if (expq.size() == 0) fin = 1'b1;
      end
      @(negedge clk);
      cyc++;
      check("run_inv", inv_seen, 32'(exp_inv));
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_op = '0; cfg_rpt = '0;
    cfg_len = '0; cfg_loops = '0; start = 1'b0; abort = 1'b0; kp_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", kp_req, 0);
    check("rst_kctrl", k_ctrl, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_inv", inv_seen, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic program, full-rate ack, then stalled ack, then back-to-back starts.
    write_entry(0, 8, 0);
    write_entry(1, 9, 2);
    run_prog(2, 1, 0, 1'b0, 1'b0);
    idle_cycle();
    run_prog(2, 1, 1, 1'b0, 1'b0);
    idle_cycle();
    run_prog(2, 0, 0, 1'b0, 1'b0);
    run_prog(2, 0, 2, 1'b0, 1'b0);
    idle_cycle();

    // Invalid opcode in the middle; flag stays set while idle.
    write_entry(1, 3, 0);
    write_entry(2, 9, 0);
    run_prog(3, 0, 0, 1'b0, 1'b0);
    idle_cycle();
    check("inv_sticky", inv_seen, 1);
    run_prog(3, 0, 2, 1'b1, 1'b0);
    idle_cycle();

    // Empty program.
    cfg_len = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_req", kp_req, 0);
    check("len0_busy", busy, 0);
    @(negedge clk);
    check("len0_done_clr", done, 0);

    // Abort coinciding with the third transfer, then an accepted write.
    write_entry(1, 9, 2);
    build_expected(2, 1);
    cfg_len = 5'd2; cfg_loops = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_token", k_ctrl, expq[0]);
      void'(expq.pop_front());
      kp_ack = 1'b1;
      abort = (i == 2);
      @(negedge clk);
    end
    abort = 1'b0; kp_ack = 1'b0;
    check("abort_req", kp_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    write_entry(1, 13, 1);
    check("abort_no_done", done, 0);
    run_prog(2, 0, 0, 1'b0, 1'b0);
    idle_cycle();

    // Write, start and abort together in IDLE: start sees the old entry 0.
    run_prog(2, 0, 2, 1'b0, 1'b1);
    idle_cycle();
    run_prog(2, 0, 0, 1'b0, 1'b0);
    idle_cycle();

    // Asynchronous reset in the middle of a run.
    write_entry(0, 8, 0);
    write_entry(1, 3, 0);
    write_entry(2, 9, 1);
    cfg_len = 5'd3; cfg_loops = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; kp_ack = 1'b1;
    check("mid_tok0", k_ctrl, 8);
    @(negedge clk);
    check("mid_tok1", k_ctrl, 3);
    @(negedge clk);
    check("mid_tok2", k_ctrl, 9);
    check("mid_inv", inv_seen, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_req", kp_req, 0);
    check("arst_kctrl", k_ctrl, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_inv", inv_seen, 0);
    @(negedge clk);
    reset = 1'b0; kp_ack = 1'b0;
    @(negedge clk);
    check("post_rst_done", done, 0);
    run_prog(3, 0, 0, 1'b0, 1'b0);
    idle_cycle();

    // Randomized programs, including the full-depth case.
    for (int t = 0; t < 6; t++) begin
      int len;
      for (int i = 0; i < 16; i++) write_entry(i, $urandom_range(0, 15), $urandom_range(0, 3));
      len = (t == 0) ? 16 : $urandom_range(1, 16);
      run_prog(len, $urandom_range(0, 2), 2, 1'($urandom_range(0, 1)), 1'b0);
      idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operm_kp_seq.md
# operm_kp_seq

Kernel-program sequencer for the operand-permute join stage. Holds a small program of (opcode, repeat) entries and replays it as a stream of `k_ctrl` tokens on the kp request/acknowledge handshake, with per-entry repeat and whole-program loop counters. It sits upstream of the operand-permute control join and replaces host-driven per-token kp requests.

## Interface

Parameters:
- `DEPTH`, 16: program entries; power of two. `AW = log2(DEPTH)`.
- `CNTW`, 8: width of the repeat and loop counters.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `cfg_we`, in, 1: program write strobe. Ignored while `busy`.
- `cfg_addr`, in, AW: entry index for the write.
- `cfg_op`, in, 4: opcode to store.
- `cfg_rpt`, in, CNTW: repeat count; the entry is issued `cfg_rpt+1` times.
- `cfg_len`, in, AW+1: number of entries in the program, 0..DEPTH. Sampled on `start`.
- `cfg_loops`, in, CNTW: program is replayed `cfg_loops+1` times. Sampled on `start`.
- `start`, in, 1: begin sequencing. Ignored while `busy`.
- `abort`, in, 1: stop sequencing and return to IDLE.
- `kp_req`, out, 1: token valid.
- `kp_ack`, in, 1: downstream accepts the token. A transfer occurs when `kp_req & kp_ack`.
- `k_ctrl`, out, 4: token opcode.
- `busy`, out, 1: high in ISSUE.
- `done`, out, 1: one-cycle pulse on normal completion.
- `inv_seen`, out, 1: sticky flag. Set when an issued token's opcode is not in {8, 9, 13, 14, 15}. Cleared on accepted `start`.

## Operation

- States: IDLE, ISSUE.
- IDLE:
  - `cfg_we` writes `{cfg_op, cfg_rpt}` to `mem[cfg_addr]`.
  - `start` latches `len` and `loop_cnt = cfg_loops`, sets `pc = 0` and `rpt_cnt = mem[0].rpt`, loads `k_ctrl = mem[0].op`, asserts `kp_req`, and moves to ISSUE.
  - `start` with `cfg_len == 0`: no tokens are issued. `done` pulses on the next cycle and the state stays IDLE.
- ISSUE, on each transfer:
  - If `rpt_cnt != 0`: decrement `rpt_cnt`. `k_ctrl` is unchanged.
  - Else if `pc != len-1`: advance `pc`, reload `rpt_cnt` and `k_ctrl` from `mem[pc+1]`.
  - Else if `loop_cnt != 0`: decrement `loop_cnt`, set `pc = 0`, reload from `mem[0]`.
  - Else: deassert `kp_req`, pulse `done`, go to IDLE.
- Handshake:
  - `k_ctrl` is held stable while `kp_req & ~kp_ack`.
  - The next token is loaded at the same edge as the transfer, with no bubble. This needs a lookahead combinational read of the next entry.
- Invalid opcodes are issued unchanged; the downstream join discards them. `inv_seen` sets at the transfer of any invalid token.
- Abort in ISSUE:
  - `kp_req` drops at the next edge, the state goes to IDLE, and `done` is not pulsed.
  - If `abort` and a transfer occur in the same cycle, the transfer counts and the abort still wins.
  - The downstream join only acknowledges while `kp_req` is high, so withdrawing the request is safe.
- Total tokens per run: `(cfg_loops+1) × Σ(rpt_i+1)` over `i < len`.
- Counter arithmetic is unsigned with no wrap: the decrements are guarded by `!= 0`.
- Program memory is not reset. Entries at or beyond `len` are never read.

## Timing

- Reset values: `kp_req=0`, `k_ctrl=0`, `busy=0`, `done=0`, `inv_seen=0`, state IDLE, all counters 0.
- Reset mid-run: outputs return to their reset values immediately (asynchronously); no `done` pulse.
- `start` sampled at edge N gives `kp_req=1` and `busy=1` from edge N through the cycle after.
- Sustained throughput is 1 token per cycle while `kp_ack=1`.
- Final transfer at edge M: `done=1` and `busy=0` in cycle M+1, and `kp_req=0` from M.
- A new `start` is accepted in cycle M+1, back-to-back.
- A write to `mem[k]` in the cycle before `start` is visible to that run.
- `cfg_we`, `start` and `abort` asserted simultaneously in IDLE: the write and the start both take effect. Start reads the pre-write value if `cfg_addr == 0`. `abort` has no effect in IDLE.

## Structure

- Shared package `operm_pkg`:
  - opcode constants `OP_P8`, `OP_P9`, `OP_P13`, `OP_P14`, `OP_P15`;
  - function `is_valid_op(op)`;
  - state enum `kpseq_state_t`.
- The existing join control also uses this package, so the valid-op set has a single definition.
- Sub-module `operm_prog_mem`: DEPTH × (4+CNTW) register file with synchronous write, two asynchronous read ports (current and lookahead) and no reset.

## Test plan

- Program {(8,rpt 0),(9,rpt 2)}, len 2, loops 1, `kp_ack` tied high: exactly 8 tokens 8,9,9,9,8,9,9,9 on consecutive cycles, then `done` pulses one cycle after the last; `inv_seen=0`.
- Same program with `kp_ack` toggling 1,0,0,1,…: `k_ctrl` is stable during the stalls and the token sequence is unchanged, still 8 tokens.
- Entry (3,rpt 0) between two valid ops: token 3 is issued and `inv_seen` sets at its transfer and stays set until the next `start`.
- `len=0`, `start`: no `kp_req`, `done` pulses one cycle later.
- `abort` after 2 of 8 transfers, coinciding with the third `kp_ack`: 3 transfers total, `kp_req` drops, no `done`. A `cfg_we` in the next cycle is accepted.
- `reset` asserted mid-run and released: all outputs 0, and a new `start` replays the program from entry 0.
